// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use, branch-operand and MDU-busy stalls,
// plus the MDU busy counter and a saturating stall performance counter.
module hazard_stall_unit #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RtE,
  input  logic [4:0]        WriteRegE,
  input  logic [4:0]        WriteRegM,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MduStartD,
  input  logic              MduDivD,
  input  logic              HiLoRdD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MduBusy,
  output logic              MduDone,
  output logic [PERF_W-1:0] StallCount
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             rsLive, rtLive;
  logic             lwStall, brStall, mduStall, stall;

  // $0 is hardwired to zero, so a zero source field never creates a dependency.
  always_comb begin
    rsLive   = (RsD != '0);
    rtLive   = (RtD != '0);
    lwStall  = MemtoRegE && ((rsLive && RtE == RsD) || (rtLive && RtE == RtD));
    brStall  = BranchD &&
               ((RegWriteE && ((rsLive && WriteRegE == RsD) || (rtLive && WriteRegE == RtD))) ||
                (MemtoRegM && ((rsLive && WriteRegM == RsD) || (rtLive && WriteRegM == RtD))));
    mduStall = MduBusy && (HiLoRdD || MduStartD);
    stall    = lwStall | brStall | mduStall;
  end

  assign StallF  = stall;
  assign StallD  = stall;
  assign FlushE  = stall;
  assign MduBusy = (cnt != '0);
  assign MduDone = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (MduStartD && !stall) begin
      cnt <= MduDivD ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (stall && StallCount != '1) begin
      StallCount <= StallCount + PERF_W'(1);
    end
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Decode-stage hazard controller for the 5-stage MIPS pipeline; companion to the forwarding units (data_forward, data_forward_b).
- Handles the hazards forwarding cannot resolve: load-use, branch compare operand not yet available, and HI/LO access while the multi-cycle multiply/divide unit (MDU) is busy.
- Owns the MDU busy counter and a saturating stall performance counter.
- Drives StallF, StallD and FlushE into the IF/ID and ID/EX pipeline registers.

Parameters:
- MULT_CYCLES, 4, cycles the MDU is busy after a mult/multu issue (1..2^CNT_W-1)
- DIV_CYCLES, 32, cycles the MDU is busy after a div/divu issue (1..2^CNT_W-1)
- CNT_W, 6, MDU counter width
- PERF_W, 16, stall performance counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- RsD  in  5  decode source register rs
- RtD  in  5  decode source register rt
- RtE  in  5  execute-stage rt (load destination)
- WriteRegE  in  5  execute-stage destination register
- WriteRegM  in  5  memory-stage destination register
- RegWriteE  in  1  execute-stage instruction writes the register file
- MemtoRegE  in  1  execute-stage instruction is a load
- MemtoRegM  in  1  memory-stage instruction is a load
- BranchD  in  1  decode-stage instruction is beq/bne
- MduStartD  in  1  decode-stage instruction is mult/multu/div/divu
- MduDivD  in  1  with MduStartD: 1 = divide, 0 = multiply
- HiLoRdD  in  1  decode-stage instruction is mfhi/mflo
- StallF  out  1  hold the PC
- StallD  out  1  hold IF/ID
- FlushE  out  1  clear ID/EX (insert bubble)
- MduBusy  out  1  MDU counter nonzero
- MduDone  out  1  final busy cycle of the MDU operation
- StallCount  out  PERF_W  saturating count of stalled cycles

Behaviour:
- Register $0 never causes a hazard. Every source match below also requires the source field != 0.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- brstall = BranchD && ((RegWriteE && WriteRegE ∈ {RsD,RtD}) || (MemtoRegM && WriteRegM ∈ {RsD,RtD})).
- mdustall = MduBusy && (HiLoRdD || MduStartD).
- stall = lwstall | brstall | mdustall. StallF = StallD = FlushE = stall, all combinational, same cycle.
- MDU counter cnt (CNT_W bits):
  - Reset: 0.
  - If MduStartD && !stall at a clock edge: cnt loads DIV_CYCLES if MduDivD, else MULT_CYCLES.
  - Else if cnt != 0: cnt decrements.
  - Load has priority over decrement. Load while busy cannot occur, because mdustall blocks it.
- MduBusy = (cnt != 0). MduDone = (cnt == 1). Both are decoded from the registered state, so there is no combinational path from inputs.
- Issue timing: a mult accepted in cycle t gives MduBusy=1 in cycles t+1..t+MULT_CYCLES and MduDone=1 in cycle t+MULT_CYCLES. A dependent mfhi in cycle t+1 stalls through t+MULT_CYCLES and proceeds in t+MULT_CYCLES+1.
- StallCount:
  - Reset: 0.
  - Increments by 1 at each edge where stall=1.
  - Holds at 2^PERF_W-1; no wrap.
- Reset state: cnt=0, StallCount=0, so MduBusy=0 and MduDone=0. StallF/StallD/FlushE follow the combinational inputs (0 while the inputs are idle).
- Reset asserted mid-operation: the next edge clears cnt and StallCount unconditionally, overriding any load or increment.
- Simultaneous hazards: the outputs are an OR of all terms. StallCount increments once per cycle regardless of how many terms are active.
- BranchD with the operand in M produced by a non-load: no stall; data_forward_b covers that case.

Test Plan:
- lw $5 in E (MemtoRegE=1, RtE=5), RsD=5 -> StallF=StallD=FlushE=1 that cycle; StallCount 0->1. Repeat with RtE=0, RsD=0 -> no stall.
- beq in D, RsD=10, RegWriteE=1, WriteRegE=10 -> stall=1. Same with RegWriteE=0, MemtoRegM=1, WriteRegM=10 -> stall=1. MemtoRegM=0 -> stall=0.
- mult issued (MduStartD=1, MduDivD=0) at cycle 0, then HiLoRdD=1 held from cycle 1 -> MduBusy=1 in cycles 1-4, MduDone=1 in cycle 4, stall=1 in cycles 1-4, stall=0 in cycle 5; StallCount=4.
- div issued, then a second mult in D at cycle 1 -> mult stalls 32 cycles, is accepted in cycle 33, MduBusy=1 in cycles 34-37.
- Force StallCount to saturate (PERF_W=4, 20 stall cycles) -> StallCount holds at 15.
- Div issued, rst_n=0 at cycle 10 -> cnt=0 and MduBusy=0 from cycle 11; StallCount=0; pending HiLoRdD is no longer stalled.
